// File: rtl/p_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack port and fills IF/ID,
// with a one-entry skid buffer for stalls. Define FETCH_STATS_EN to add event counters.
module p_fetch_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] START_PC = ADDR_W'(32'h0040_0000),
   parameter int unsigned       PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_pc,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              ifid_valid,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic [ADDR_W-1:0] ifid_pc4,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]       stat_fetched,
   output logic [15:0]       stat_flushed,
   output logic [31:0]       stat_stall_cyc
`endif
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

   localparam logic [ADDR_W-1:0] Step = ADDR_W'(PC_STEP);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d, pend_q, pend_d;
   logic                squash_q, squash_d;
   logic                ifid_valid_q, ifid_valid_d;
   logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d, ifid_pc4_q, ifid_pc4_d;
   logic [DATA_W-1:0]   ifid_instr_q, ifid_instr_d;
   logic                skid_valid_q, skid_valid_d;
   logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
   logic [DATA_W-1:0]   skid_instr_q, skid_instr_d;
   logic                redir, accept;
   logic [ADDR_W-1:0]   redir_target;

   // load_pc outside IDLE behaves as a redirect to START_PC; redirect has priority.
   assign redir        = (state_q != StIdle) && (redirect || load_pc);
   assign redir_target = redirect ? redirect_pc : START_PC;
   assign accept       = (state_q == StFetch) && imem_ack && !squash_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_d       = pend_q;
      squash_d     = squash_q;
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if (state_q == StIdle) begin
         if (load_pc) begin
            pc_d    = START_PC;
            state_d = StFetch;
         end
      end else if (redir) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = '0;
         skid_valid_d = 1'b0;
         // An outstanding request cannot be cancelled: remember the target and drop its word.
         if (state_q == StFetch && !imem_ack) begin
            squash_d = 1'b1;
            pend_d   = redir_target;
         end else begin
            squash_d = 1'b0;
            pc_d     = redir_target;
            state_d  = StFetch;
         end
      end else if (state_q == StHold) begin
         if (!stall) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_pc4_d   = skid_pc_q + Step;
            ifid_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
            state_d      = StFetch;
         end
      end else begin
         if (imem_ack && squash_q) begin
            squash_d = 1'b0;
            pc_d     = pend_q;
         end
         if (!stall || !ifid_valid_q) begin
            ifid_valid_d = accept;
            if (accept) begin
               ifid_pc_d    = pc_q;
               ifid_pc4_d   = pc_q + Step;
               ifid_instr_d = imem_rdata;
               pc_d         = pc_q + Step;
            end else begin
               ifid_instr_d = '0;
            end
         end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            pc_d         = pc_q + Step;
            state_d      = StHold;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         pc_q         <= START_PC;
         pend_q       <= START_PC;
         squash_q     <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= '0;
         ifid_instr_q <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_q       <= pend_d;
         squash_q     <= squash_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   assign imem_req   = (state_q == StFetch);
   assign imem_addr  = pc_q;
   assign ifid_valid = ifid_valid_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_pc4   = ifid_pc4_q;
   assign ifid_instr = ifid_instr_q;
   assign pc_out     = pc_q;

`ifdef FETCH_STATS_EN
   logic fetched_ev, flush_ev;

   assign fetched_ev = !redir && ((state_q == StHold && !stall) ||
                                  (accept && (!stall || !ifid_valid_q)));
   // A flush counts only if it threw away a live word somewhere in the stage.
   assign flush_ev   = redir && (ifid_valid_q || skid_valid_q ||
                                 (state_q == StFetch && !squash_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetched   <= '0;
         stat_flushed   <= '0;
         stat_stall_cyc <= '0;
      end else begin
         if (fetched_ev) stat_fetched <= stat_fetched + 32'd1;
         if (flush_ev) stat_flushed <= stat_flushed + 16'd1;
         if (stall && ifid_valid_q) stat_stall_cyc <= stat_stall_cyc + 32'd1;
      end
   end
`else
   // Counters are not built; the stage behaves identically without them.
`endif

endmodule

// File: tb/tb_p_fetch_stage.sv
// Bench for p_fetch_stage: directed scenarios then random stall/redirect traffic, checked by a
// scoreboard holding the expected program-order PC stream consumed by decode.
module tb_p_fetch_stage;

   localparam logic [31:0] START = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset, load_pc, stall, redirect;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_pc, ifid_pc4, ifid_instr, pc_out;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched, stat_stall_cyc;
   logic [15:0] stat_flushed;
`endif

   int unsigned total = 0, bad = 0;
   int unsigned lat = 0, wait_cnt = 0;
   bit          running = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] nxt;
   int unsigned consumed = 0, gap = 0;

   p_fetch_stage dut (
      .clk(clk), .reset(reset), .load_pc(load_pc), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
      .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .pc_out(pc_out)
`ifdef FETCH_STATS_EN
      , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed),
      .stat_stall_cyc(stat_stall_cyc)
`endif
   );

   always #5 clk = ~clk;

   // Memory: returns the address as data after lat wait cycles.
   assign imem_ack   = imem_req && (wait_cnt >= lat);
   assign imem_rdata = imem_ack ? imem_addr : 32'hDEAD_BEEF;
   always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void refill();
      while (exp_q.size() != 0 && exp_q.size() < 8) begin
         exp_q.push_back(nxt);
         nxt = nxt + 32'd4;
      end
   endfunction

   function automatic void start_stream(logic [31:0] target);
      exp_q.delete();
      exp_q.push_back(target);
      nxt = target + 32'd4;
      refill();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      refill();
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_redirect(logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      start_stream(target);
   endtask

   task automatic check_reset(string tag);
      check({tag, "_req"}, 32'(imem_req), 32'd0);
      check({tag, "_addr"}, imem_addr, START);
      check({tag, "_pc_out"}, pc_out, START);
      check({tag, "_valid"}, 32'(ifid_valid), 32'd0);
      check({tag, "_ifid_pc"}, ifid_pc, 32'd0);
      check({tag, "_ifid_pc4"}, ifid_pc4, 32'd0);
      check({tag, "_instr"}, ifid_instr, 32'd0);
   endtask

   task automatic wait_ack(string name);
      int n = 0;
      sample();
      while (!imem_ack && n < 20) begin
         tick();
         sample();
         n++;
      end
      check(name, 32'(imem_ack), 32'd1);
   endtask

   task automatic wait_no_req(string name);
      int n = 0;
      sample();
      while (imem_req && n < 20) begin
         tick();
         sample();
         n++;
      end
      check(name, 32'(imem_req), 32'd0);
   endtask

`ifdef FETCH_STATS_EN
   int unsigned m_fetched = 0, m_flushed = 0, m_stall = 0;
   bit          prev_free = 1'b1, tb_squash = 1'b0;

   task automatic check_stats(string tag);
      #1;
      check({tag, "_fetched"}, stat_fetched, m_fetched);
      check({tag, "_flushed"}, 32'(stat_flushed), 32'(m_flushed[15:0]));
      check({tag, "_stall"}, stat_stall_cyc, m_stall);
   endtask
`endif

   // Monitor: decode consumes IF/ID when valid, not stalled and not flushed this cycle.
   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr = '0;
   always @(negedge clk) begin
      logic        eff, cons;
      logic [31:0] e;
      eff  = running && (redirect || load_pc);
      cons = !reset && ifid_valid && !stall && !eff;
      if (!reset) begin
         if (!ifid_valid) check("nop_when_invalid", ifid_instr, 32'd0);
         if (cons) begin
            if (exp_q.size() == 0) begin
               check("stream_unexpected", ifid_pc, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("stream_pc", ifid_pc, e);
               check("stream_pc4", ifid_pc4, e + 32'd4);
               check("stream_instr", ifid_instr, e);
            end
            consumed++;
            gap = 0;
         end else if (running && !eff) begin
            gap++;
         end else begin
            gap = 0;
         end
         if (gap > 40) begin
            check("stream_gap", gap, 32'd40);
            gap = 0;
         end
         if (prev_wait) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, prev_addr);
         end
      end
      prev_wait = !reset && imem_req && !imem_ack;
      prev_addr = imem_addr;
`ifdef FETCH_STATS_EN
      if (reset) begin
         m_fetched = 0; m_flushed = 0; m_stall = 0;
         prev_free = 1'b1; tb_squash = 1'b0;
      end else begin
         if (ifid_valid && prev_free) m_fetched++;
         if (stall && ifid_valid) m_stall++;
         if (eff && (ifid_valid || !imem_req || !tb_squash)) m_flushed++;
         if (eff) tb_squash = imem_req && !imem_ack;
         else if (imem_ack) tb_squash = 1'b0;
         prev_free = !ifid_valid || cons || eff;
      end
`endif
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned stall_run = 0;
      int unsigned start_cons;
      logic [31:0] r;
      reset = 1'b1; load_pc = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      // 1: reset, load, back-to-back zero-wait fetch
      tick(); tick();
      reset = 1'b0;
      sample(); check_reset("rst");
      tick(); sample(); check("idle_no_req", 32'(imem_req), 32'd0);
      tick(); load_pc = 1'b1; start_stream(START);
      tick(); load_pc = 1'b0; running = 1'b1;
      sample();
      check("f1_addr0", imem_addr, START);
      check("f1_req", 32'(imem_req), 32'd1);
      check("f1_valid0", 32'(ifid_valid), 32'd0);
      tick(); sample();
      check("f1_addr1", imem_addr, START + 32'd4);
      check("f1_ifid0", ifid_pc, START);
      // 2: three stall cycles while IF/ID holds START+4
      tick(); stall = 1'b1;
      sample();
      check("f1_addr2", imem_addr, START + 32'd8);
      check("st_ifid", ifid_pc, START + 32'd4);
      for (int i = 0; i < 2; i++) begin
         tick(); sample();
         check("st_hold_pc", ifid_pc, START + 32'd4);
         check("st_no_req", 32'(imem_req), 32'd0);
      end
      tick(); stall = 1'b0;
      sample(); check("st_rel_pc", ifid_pc, START + 32'd4);
      tick(); sample();
      check("st_skid_out", ifid_pc, START + 32'd8);
      check("st_req_back", 32'(imem_req), 32'd1);
      check("st_addr_next", imem_addr, START + 32'd12);
      // 3: redirect while a 4-cycle request is in flight
      tick(); lat = 4;
      tick(); do_redirect(START + 32'h100);
      tick(); redirect = 1'b0;
      wait_ack("sq_old_ack");
      check("sq_valid0", 32'(ifid_valid), 32'd0);
      tick(); sample();
      check("sq_new_addr", imem_addr, START + 32'h100);
      check("sq_valid1", 32'(ifid_valid), 32'd0);
      wait_ack("sq_new_ack");
      tick(); sample();
      check("sq_arrive_v", 32'(ifid_valid), 32'd1);
      check("sq_arrive_pc", ifid_pc, START + 32'h100);
      // 4: redirect and stall together with the skid full
      tick(); lat = 0; stall = 1'b1;
      wait_no_req("rs_hold");
      tick(); do_redirect(START + 32'h200);
      tick(); redirect = 1'b0; stall = 1'b0;
      sample();
      check("rs_flush_v", 32'(ifid_valid), 32'd0);
      check("rs_addr", imem_addr, START + 32'h200);
      tick(); sample();
      check("rs_ifid_pc", ifid_pc, START + 32'h200);
`ifdef FETCH_STATS_EN
      check_stats("stats_a");
`endif
      // 5: wrap past the top of the address space, then reset mid-fetch
      tick(); do_redirect(32'hFFFF_FFFC);
      tick(); redirect = 1'b0;
      sample(); check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      tick(); sample();
      check("wrap_addr_zero", imem_addr, 32'd0);
      check("wrap_ifid_pc4", ifid_pc4, 32'd0);
      tick(); reset = 1'b1; running = 1'b0; exp_q.delete();
      tick(); reset = 1'b0;
      sample(); check_reset("midrst");
      for (int i = 0; i < 2; i++) begin
         tick(); sample(); check("midrst_idle", 32'(imem_req), 32'd0);
      end
      tick(); load_pc = 1'b1; start_stream(START);
      tick(); load_pc = 1'b0; running = 1'b1;
      // Random stall/redirect/latency traffic
      start_cons = consumed;
      for (int c = 0; c < 3000; c++) begin
         tick();
         redirect = 1'b0;
         if (c % 64 == 0) lat = $urandom_range(0, 3);
         if (stall_run >= 5) stall = 1'b0;
         else stall = ($urandom_range(0, 99) < 30);
         stall_run = stall ? stall_run + 1 : 0;
         if ($urandom_range(0, 99) < 5) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            r[1:0] = 2'b00;
            do_redirect(r);
         end
      end
      tick(); redirect = 1'b0; stall = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      sample();
      check("rand_progress", 32'(consumed - start_cons > 300), 32'd1);
`ifdef FETCH_STATS_EN
      check_stats("stats_b");
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
